// File: rtl/fdct_whole.sv
// ---------------------------------------------------------------------------
// fdct_whole : 4x4 forward integer DCT (encoder-side partner of IDCT_whole)
//
// Each accepted input row goes through the row transform and lands in one half
// of a ping-pong transpose buffer. A filled half is drained through the column
// transform, one coefficient row per cycle. Blocks can stream back to back
// with no stall. There is no backpressure.
//
// Ports
//   clk                 rising-edge clock
//   reset               synchronous, active-high reset
//   in_valid            d_in_1..4 carry residual row X[r][0..3]
//   d_in_1..d_in_4      signed WIDTH-bit samples, columns 0..3
//   out_valid           d_out_1..4 carry coefficient row Y[k][0..3]
//   out_row             frequency row index k of the current output
//   d_out_1..d_out_4    signed WIDTH-bit coefficients, columns 0..3
//   sat_flag            (FDCT_SAT_FLAG_EN only) block saturated somewhere
//
// Optional feature macro: FDCT_SAT_FLAG_EN adds the sticky per-block sat_flag.
// ---------------------------------------------------------------------------
module fdct_whole #(
   parameter int WIDTH  = 25,
   parameter int SHIFT1 = 1,
   parameter int SHIFT2 = 8
) (
   input  logic                    clk,
   input  logic                    reset,
   input  logic                    in_valid,
   input  logic signed [WIDTH-1:0] d_in_1,
   input  logic signed [WIDTH-1:0] d_in_2,
   input  logic signed [WIDTH-1:0] d_in_3,
   input  logic signed [WIDTH-1:0] d_in_4,
   output logic                    out_valid,
   output logic [1:0]              out_row,
   output logic signed [WIDTH-1:0] d_out_1,
   output logic signed [WIDTH-1:0] d_out_2,
   output logic signed [WIDTH-1:0] d_out_3,
   output logic signed [WIDTH-1:0] d_out_4
`ifdef FDCT_SAT_FLAG_EN
   ,output logic                   sat_flag
`endif
);

   // A 4-term dot product with coefficients up to 83 fits in WIDTH+9 bits.
   localparam int AW = WIDTH + 9;

   typedef logic signed [WIDTH-1:0] samp_t;
   typedef logic signed [AW-1:0]    acc_t;
   typedef enum logic {IDLE = 1'b0, DRAIN = 1'b1} state_t;

   localparam acc_t SMAX = {{(AW-WIDTH+1){1'b0}}, {(WIDTH-1){1'b1}}};
   localparam acc_t SMIN = {{(AW-WIDTH+1){1'b1}}, {(WIDTH-1){1'b0}}};

   // Row k of the transform matrix applied to four samples.
   function automatic acc_t dot4(input logic [1:0] k,
                                 input samp_t a0, input samp_t a1,
                                 input samp_t a2, input samp_t a3);
      acc_t c0, c1, c2, c3;
      case (k)
         2'd0:    begin c0 = AW'(64); c1 = AW'(64);  c2 = AW'(64);  c3 = AW'(64);  end
         2'd1:    begin c0 = AW'(83); c1 = AW'(36);  c2 = AW'(-36); c3 = AW'(-83); end
         2'd2:    begin c0 = AW'(64); c1 = AW'(-64); c2 = AW'(-64); c3 = AW'(64);  end
         default: begin c0 = AW'(36); c1 = AW'(-83); c2 = AW'(83);  c3 = AW'(-36); end
      endcase
      return c0 * acc_t'(a0) + c1 * acc_t'(a1) + c2 * acc_t'(a2) + c3 * acc_t'(a3);
   endfunction

   // Round half up, then arithmetic shift (floor), at full precision.
   function automatic acc_t rnd(input acc_t v, input int s);
      acc_t half;
      half = acc_t'(1) <<< (s - 1);
      return (v + half) >>> s;
   endfunction

   function automatic samp_t clip(input acc_t r);
      if (r > SMAX) return SMAX[WIDTH-1:0];
      if (r < SMIN) return SMIN[WIDTH-1:0];
      return r[WIDTH-1:0];
   endfunction

   state_t     state, state_nx;
   logic [1:0] wcnt;          // next row slot in the block being filled
   logic       wsel;          // buffer being filled
   logic       rsel;          // buffer being (or next to be) drained
   logic [1:0] full;          // per-buffer "complete block waiting" flags
   logic       load;          // register a coefficient row this edge
   logic [1:0] load_k;        // which row is registered
   logic       last;          // the registered row is the block's final one
   acc_t       t_acc [4];
   samp_t      t_row [4];
   acc_t       y_acc [4];
   samp_t      y_col [4];
   samp_t      tbuf  [2][4][4];   // [buffer][row r][column m]

   // ---- row stage --------------------------------------------------------
   // NOTE: every always_comb output gets a value on every path (loop covers
   // all elements), so no latch can be inferred.
   always_comb begin
      for (int k = 0; k < 4; k++) begin
         t_acc[k] = rnd(dot4(2'(k), d_in_1, d_in_2, d_in_3, d_in_4), SHIFT1);
         t_row[k] = clip(t_acc[k]);
      end
   end

   // NOTE: the transpose storage has no reset; the full flags alone decide
   // whether its contents are ever read.
   always_ff @(posedge clk) begin
      if (in_valid && !reset) begin
         for (int k = 0; k < 4; k++) tbuf[wsel][wcnt][k] <= t_row[k];
      end
   end

   // ---- fill / drain bookkeeping -----------------------------------------
   // NOTE: sequential state always uses non-blocking assignment so every
   // register samples pre-edge values.
   always_ff @(posedge clk) begin
      if (reset) begin
         wcnt <= 2'd0;
         wsel <= 1'b0;
         rsel <= 1'b0;
         full <= 2'b00;
      end else begin
         if (in_valid) begin
            wcnt <= wcnt + 2'd1;
            if (wcnt == 2'd3) begin
               full[wsel] <= 1'b1;
               wsel       <= ~wsel;
            end
         end
         // The final row is captured this edge, so the buffer may be refilled.
         if (last) begin
            full[rsel] <= 1'b0;
            rsel       <= ~rsel;
         end
      end
   end

   // ---- drain FSM --------------------------------------------------------
   always_ff @(posedge clk) begin
      if (reset) state <= IDLE;
      else       state <= state_nx;
   end

   // DRAIN means the output register holds a valid row; rsel has already
   // moved on when row 3 is on display, so full[rsel] asks about the next block.
   always_comb begin
      state_nx = state;
      case (state)
         IDLE:    if (full[rsel]) state_nx = DRAIN;
         DRAIN:   if (out_row == 2'd3 && !full[rsel]) state_nx = IDLE;
         default: state_nx = IDLE;
      endcase
   end

   always_comb begin
      load   = 1'b0;
      load_k = 2'd0;
      case (state)
         IDLE:  load = full[rsel];
         DRAIN: begin
            if (out_row != 2'd3) begin
               load   = 1'b1;
               load_k = out_row + 2'd1;
            end else begin
               load = full[rsel];
            end
         end
         default: ;
      endcase
      last = load && (load_k == 2'd3);
   end

   // ---- column stage -----------------------------------------------------
   always_comb begin
      for (int m = 0; m < 4; m++) begin
         y_acc[m] = rnd(dot4(load_k, tbuf[rsel][0][m], tbuf[rsel][1][m],
                             tbuf[rsel][2][m], tbuf[rsel][3][m]), SHIFT2);
         y_col[m] = clip(y_acc[m]);
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         out_valid <= 1'b0;
         out_row   <= 2'd0;
         d_out_1   <= '0;
         d_out_2   <= '0;
         d_out_3   <= '0;
         d_out_4   <= '0;
      end else begin
         out_valid <= load;
         if (load) begin
            out_row <= load_k;
            d_out_1 <= y_col[0];
            d_out_2 <= y_col[1];
            d_out_3 <= y_col[2];
            d_out_4 <= y_col[3];
         end
      end
   end

`ifdef FDCT_SAT_FLAG_EN
   // ---- sticky saturation flag -------------------------------------------
   function automatic logic over(input acc_t r);
      return (r > SMAX) || (r < SMIN);
   endfunction

   logic [1:0] tsat;     // per buffer: some row-stage value saturated
   logic       t_ovf;
   logic       y_ovf;    // some column-stage value of buffer rsel saturates

   always_comb begin
      t_ovf = 1'b0;
      for (int k = 0; k < 4; k++) t_ovf = t_ovf | over(t_acc[k]);
   end

   // The flag is shown with row 0, so all 16 column results are screened up front.
   always_comb begin
      y_ovf = 1'b0;
      for (int k = 0; k < 4; k++) begin
         for (int m = 0; m < 4; m++) begin
            y_ovf = y_ovf | over(rnd(dot4(2'(k), tbuf[rsel][0][m], tbuf[rsel][1][m],
                                          tbuf[rsel][2][m], tbuf[rsel][3][m]), SHIFT2));
         end
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         tsat     <= 2'b00;
         sat_flag <= 1'b0;
      end else begin
         if (in_valid) tsat[wsel] <= ((wcnt == 2'd0) ? 1'b0 : tsat[wsel]) | t_ovf;
         if (load && load_k == 2'd0) sat_flag <= tsat[rsel] | y_ovf;
         else if (!load)             sat_flag <= 1'b0;
      end
   end
`endif

endmodule

// File: tb/tb_fdct_whole.sv
// ---------------------------------------------------------------------------
// tb_fdct_whole : self-checking bench for fdct_whole.
// Fixed vectors from a table, then random blocks scored against a plain
// matrix-arithmetic reference model, plus reset/partial-block sequences.
// ---------------------------------------------------------------------------
module tb_fdct_whole;
   localparam int WIDTH = 25;
   localparam int C [4][4] = '{'{64, 64, 64, 64}, '{83, 36, -36, -83},
                               '{64, -64, -64, 64}, '{36, -83, 83, -36}};

   logic clk = 1'b0;
   logic reset = 1'b1;
   logic in_valid = 1'b0;
   logic signed [WIDTH-1:0] d_in_1 = '0, d_in_2 = '0, d_in_3 = '0, d_in_4 = '0;
   logic out_valid;
   logic [1:0] out_row;
   logic signed [WIDTH-1:0] d_out_1, d_out_2, d_out_3, d_out_4;
`ifdef FDCT_SAT_FLAG_EN
   logic sat_flag;
`endif

   always #5 clk = ~clk;

   fdct_whole dut (
      .clk(clk), .reset(reset), .in_valid(in_valid),
      .d_in_1(d_in_1), .d_in_2(d_in_2), .d_in_3(d_in_3), .d_in_4(d_in_4),
      .out_valid(out_valid), .out_row(out_row),
      .d_out_1(d_out_1), .d_out_2(d_out_2), .d_out_3(d_out_3), .d_out_4(d_out_4)
`ifdef FDCT_SAT_FLAG_EN
      ,.sat_flag(sat_flag)
`endif
   );

   typedef struct { string name; int x[16]; int y[16]; bit sat; } vec_t;
   typedef struct { string name; int row; int d[4]; longint cyc; bit sat; } exp_t;

   exp_t   expq[$];
   int     errors = 0;
   int     checks = 0;
   longint cyc = 0;
   int     last_d[4];
   vec_t   tbl[4];

   task automatic check(input string name, input logic signed [63:0] act,
                        input logic signed [63:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0d, expected %0d", name, act, exp);
      end
   endtask

   // ---- reference model: plain matrix arithmetic with floor division -------
   function automatic longint rnd_sat(input longint v, input int s, inout bit sat);
      longint d, n, q;
      d = longint'(1) << s;
      n = v + d / 2;
      q = n / d;
      if (n < 0 && (n % d) != 0) q = q - 1;
      if (q > 16777215)       begin q = 16777215;  sat = 1'b1; end
      else if (q < -16777216) begin q = -16777216; sat = 1'b1; end
      return q;
   endfunction

   function automatic void model(input int x[16], output int y[16], output bit sat);
      longint t[16];
      longint acc;
      bit s;
      s = 1'b0;
      for (int r = 0; r < 4; r++)
         for (int k = 0; k < 4; k++) begin
            acc = 0;
            for (int j = 0; j < 4; j++) acc += longint'(C[k][j]) * x[r*4+j];
            t[r*4+k] = rnd_sat(acc, 1, s);
         end
      for (int k = 0; k < 4; k++)
         for (int m = 0; m < 4; m++) begin
            acc = 0;
            for (int r = 0; r < 4; r++) acc += longint'(C[k][r]) * t[r*4+m];
            y[k*4+m] = int'(rnd_sat(acc, 8, s));
         end
      sat = s;
   endfunction

   function automatic void rand_block(input int mode, output int x[16]);
      logic signed [WIDTH-1:0] v;
      for (int i = 0; i < 16; i++) begin
         case (mode)
            0: x[i] = int'($urandom_range(0, 511)) - 256;
            1: begin v = WIDTH'($urandom()); x[i] = int'(v); end
            default: x[i] = ($urandom_range(0, 1) == 1) ? 16777215 : -16777216;
         endcase
      end
   endfunction

   // ---- clocking / monitoring (single thread, no races) ------------------
   task automatic monitor();
      exp_t e;
      logic signed [WIDTH-1:0] dv[4];
      if (out_valid === 1'b1) begin
         if (expq.size() == 0) begin
            checks++;
            errors++;
            $display("FAIL unexpected_row: got out_valid=1 out_row=%0d at cycle %0d, expected no output",
                     out_row, cyc);
         end else begin
            e = expq.pop_front();
            dv = '{d_out_1, d_out_2, d_out_3, d_out_4};
            check($sformatf("%s out_row", e.name), out_row, e.row);
            for (int i = 0; i < 4; i++)
               check($sformatf("%s k%0d lane%0d", e.name, e.row, i), dv[i], e.d[i]);
            check($sformatf("%s k%0d cycle", e.name, e.row), cyc, e.cyc);
`ifdef FDCT_SAT_FLAG_EN
            check($sformatf("%s k%0d sat_flag", e.name, e.row), sat_flag, e.sat);
`endif
            last_d = e.d;
         end
      end
   endtask

   task automatic tick();
      @(posedge clk);
      cyc++;
      @(negedge clk);
      monitor();
   endtask

   task automatic push_block(input string name, input int y[16], input bit sat,
                             input longint n);
      exp_t e;
      for (int k = 0; k < 4; k++) begin
         e.name = name;
         e.row  = k;
         e.d    = '{y[k*4], y[k*4+1], y[k*4+2], y[k*4+3]};
         e.cyc  = n + 1 + k;     // row 0 one cycle after the 4th row's edge
         e.sat  = sat;
         expq.push_back(e);
      end
   endtask

   task automatic send_block(input string name, input int x[16], input int y[16],
                             input bit sat, input int gap);
      for (int r = 0; r < 4; r++) begin
         in_valid = 1'b1;
         d_in_1 = WIDTH'(x[r*4]);
         d_in_2 = WIDTH'(x[r*4+1]);
         d_in_3 = WIDTH'(x[r*4+2]);
         d_in_4 = WIDTH'(x[r*4+3]);
         if (r == 3) push_block(name, y, sat, cyc + 1);
         tick();
         if (gap > 0 && r < 3) begin
            in_valid = 1'b0;
            repeat (gap) tick();
         end
      end
      in_valid = 1'b0;
   endtask

   task automatic wait_drain(input string name);
      for (int i = 0; i < 20 && expq.size() > 0; i++) tick();
      check($sformatf("%s drained", name), expq.size(), 0);
      expq.delete();
   endtask

   task automatic random_block(input string name, input int mode, input int gap);
      int x[16];
      int y[16];
      bit s;
      rand_block(mode, x);
      model(x, y, s);
      send_block(name, x, y, s, gap);
   endtask

   // ---- main sequence ----------------------------------------------------
   initial begin
      int x[16];
      int y[16];
      bit s;

      // Reset state
      reset = 1'b1;
      tick();
      tick();
      check("reset out_valid", out_valid, 0);
      check("reset out_row", out_row, 0);
      check("reset d_out_1", d_out_1, 0);
      check("reset d_out_2", d_out_2, 0);
      check("reset d_out_3", d_out_3, 0);
      check("reset d_out_4", d_out_4, 0);
`ifdef FDCT_SAT_FLAG_EN
      check("reset sat_flag", sat_flag, 0);
`endif
      reset = 1'b0;
      tick();

      // Fixed vectors
      tbl[0].name = "dc";     tbl[0].x = '{default: 10};  tbl[0].y = '{default: 0};
      tbl[0].y[0] = 1280;     tbl[0].sat = 1'b0;
      tbl[1].name = "neg_dc"; tbl[1].x = '{default: -10}; tbl[1].y = '{default: 0};
      tbl[1].y[0] = -1280;    tbl[1].sat = 1'b0;
      tbl[2].name = "impulse"; tbl[2].x = '{default: 0};  tbl[2].x[0] = 100;
      tbl[2].y = '{800, 1038, 800, 450, 1038, 1346, 1038, 584,
                   800, 1038, 800, 450, 450, 584, 450, 253};
      tbl[2].sat = 1'b0;
      tbl[3].name = "saturate"; tbl[3].x = '{default: 16777215}; tbl[3].y = '{default: 0};
      tbl[3].y[0] = 16777215; tbl[3].sat = 1'b1;

      for (int v = 0; v < 4; v++) begin
         send_block(tbl[v].name, tbl[v].x, tbl[v].y, tbl[v].sat, 0);
         wait_drain(tbl[v].name);
         tick();
         check($sformatf("%s idle out_valid", tbl[v].name), out_valid, 0);
         check($sformatf("%s hold out_row", tbl[v].name), out_row, 3);
         check($sformatf("%s hold d_out_1", tbl[v].name), d_out_1, tbl[v].y[12]);
         check($sformatf("%s hold d_out_4", tbl[v].name), d_out_4, tbl[v].y[15]);
      end

      // Back-to-back: three blocks on 12 consecutive in_valid cycles
      for (int b = 0; b < 3; b++) random_block($sformatf("b2b%0d", b), 0, 0);
      wait_drain("b2b");

      // Partial block held across a long idle stretch
      random_block("held", 1, 8);
      wait_drain("held");

      // Random streams with mixed ranges and gaps
      for (int b = 0; b < 12; b++)
         random_block($sformatf("rnd%0d", b), b % 3, int'($urandom_range(0, 2)));
      wait_drain("rnd");

      // Reset while row 1 of a block is on the output and a second block is half filled
      rand_block(0, x);
      model(x, y, s);
      send_block("pre_reset", x, y, s, 0);
      rand_block(0, x);
      in_valid = 1'b1;
      d_in_1 = WIDTH'(x[0]); d_in_2 = WIDTH'(x[1]); d_in_3 = WIDTH'(x[2]); d_in_4 = WIDTH'(x[3]);
      tick();                       // row 0 of pre_reset shown
      d_in_1 = WIDTH'(x[4]); d_in_2 = WIDTH'(x[5]); d_in_3 = WIDTH'(x[6]); d_in_4 = WIDTH'(x[7]);
      tick();                       // row 1 of pre_reset shown
      check("mid_drain out_row", out_row, 1);
      reset = 1'b1;                 // in_valid stays high: must be ignored
      expq.delete();
      tick();
      check("mid_reset out_valid", out_valid, 0);
      check("mid_reset out_row", out_row, 0);
      check("mid_reset d_out_1", d_out_1, 0);
      reset = 1'b0;
      in_valid = 1'b0;
      tick();
      check("post_reset out_valid", out_valid, 0);
      random_block("post_reset", 0, 0);
      wait_drain("post_reset");
      repeat (3) tick();

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule

// File: doc/fdct_whole.md
Name: fdct_whole

Overview:
- 4x4 forward integer DCT, the encoder-side counterpart of the 2-D inverse transform block IDCT_whole.
- Accepts one 4-sample residual row per valid cycle and runs a row transform into a ping-pong transpose buffer.
- Runs a column transform and emits one 4-coefficient row per cycle on the same 4-lane, 25-bit signed bus format IDCT_whole consumes.
- Streams back-to-back blocks with no stall and no backpressure.

Parameters:
- WIDTH, 25, signed width of every data lane in and out.
- SHIFT1, 1, right shift after the row stage (rounded).
- SHIFT2, 8, right shift after the column stage (rounded).

Ports:
- clk  input  1  clock; all state updates on rising edge.
- reset  input  1  synchronous, active-high reset.
- in_valid  input  1  d_in_1..4 hold input row X[r][0..3] this cycle.
- d_in_1..d_in_4  input  WIDTH each  signed samples X[r][0..3], column 0..3.
- out_valid  output  1  d_out_1..4 hold a coefficient row.
- out_row  output  2  frequency row index k of the current output.
- d_out_1..d_out_4  output  WIDTH each  signed coefficients Y[k][0..3].

Behaviour:
- Transform matrix C, rows k=0..3:
  - k=0: [64 64 64 64]
  - k=1: [83 36 -36 -83]
  - k=2: [64 -64 -64 64]
  - k=3: [36 -83 83 -36]
- Row stage, per accepted row r: T[r][k] = rnd(sum_j C[k][j]*X[r][j], SHIFT1).
- Column stage: Y[k][m] = rnd(sum_r C[k][r]*T[r][m], SHIFT2).
- Rounding: rnd(v,s) = (v + 2^(s-1)) >>> s, arithmetic shift, computed at full precision (WIDTH+9 bits).
- Saturation: both T and Y saturate to signed WIDTH, i.e. [-2^24, 2^24-1]. No wrap.
- Fill side:
  - 2-bit row counter plus a write-select bit choosing buffer A or B.
  - Each in_valid cycle writes T[r] into the selected buffer and increments the counter.
  - On the 4th row (counter 3 to 0), mark that buffer full and toggle the write-select.
  - Idle cycles (in_valid=0) between rows are allowed; a partial block is held indefinitely.
- Drain side, FSM states IDLE, DRAIN:
  - IDLE to DRAIN when a buffer is full.
  - DRAIN emits k=0,1,2,3 on 4 consecutive cycles from the full buffer, registered outputs.
  - After k=3, clear that buffer's full flag. Go to IDLE, or stay in DRAIN if the other buffer is already full, which gives seamless back-to-back output.
- Latency: 4th row sampled at edge N gives Y row 0 valid after edge N+1. Rows 1..3 follow after N+2..N+4.
- Overflow is impossible: drain takes exactly 4 cycles and fill takes at least 4, so a buffer never receives writes while still full.
- Output values:
  - out_valid=0 outside DRAIN.
  - d_out_* and out_row hold their last value when out_valid=0.
  - Reset values: out_valid=0, out_row=0, d_out_1..4=0.
- Reset, including mid-block or mid-drain:
  - Discards partial and full blocks: counters, full flags and write-select go to 0, FSM goes to IDLE.
  - out_valid=0 from the cycle after reset is sampled.
  - in_valid is ignored while reset=1.
- Buffer contents need no reset; the full flags alone gate output.

Optional Feature:
- Macro FDCT_SAT_FLAG_EN.
- Defined:
  - Adds output port sat_flag (1 bit, reset 0).
  - Sticky per block: set if any T or Y value of that block saturated.
  - Presented with all 4 out_valid rows of that block; cleared when the block's drain completes.
- Undefined: port and logic absent; saturation behaviour unchanged.

Test Plan:
- DC: 4 rows all X=10 -> row k=0 {1280,0,0,0}; rows 1..3 all zeros; first out_valid exactly 1 cycle after 4th row.
- Negative DC: all X=-10 -> Y[0][0]=-1280, all others 0; checks arithmetic-shift rounding.
- Impulse: X[0][0]=100, rest 0 -> Y row 0 = {800,1038,800,450}, where Y[0][m]=rnd(64*T[0][m],8) with T[0]={3200,4150,3200,1800}.
- Back-to-back: 3 blocks on 12 consecutive in_valid cycles -> 12 consecutive out_valid cycles, out_row 0,1,2,3 repeating, each block matching its golden model.
- Saturation: all X=16777215 -> T saturates; Y[0][0]=16777215, rest 0; sat_flag=1 on all 4 rows when FDCT_SAT_FLAG_EN is defined.
- Reset mid-drain: assert reset during out_row=1 -> out_valid=0 next cycle; a new full block afterward drains correctly with no stale rows.
